// File: rtl/wb_timer_pkg.sv
// Register map, CTRL/STATUS bit positions and byte-lane helper for wb_timer.
// Shared by the timer top, its prescaler and any software-facing models.
package wb_timer_pkg;

  // Word index taken from wb_addr_i[4:2]
  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_LOAD   = 3'd1;
  localparam logic [2:0] TMR_COUNT  = 3'd2;
  localparam logic [2:0] TMR_STATUS = 3'd3;
  localparam logic [2:0] TMR_CAP    = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PRE_LSB = 8;
  localparam int CTRL_PRE_MSB = 15;

  localparam int STATUS_PEND  = 0;
  localparam int STATUS_CPEND = 1;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle between wb_conmax_top slave port and wb_timer.
// Signal names keep the slave-side view used throughout the interconnect.
interface wb_timer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [3:0]            wb_sel_i;
  logic                  wb_we_i;
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  wb_rty_o;

  modport master (
    output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_data_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_data_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_timer_prescaler.sv
// Prescaler for wb_timer: emits one tick every (pre+1) enabled cycles.
// clr restarts the count when the timer is switched on.
module wb_timer_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] pre,
  output logic             tick
);

  logic [WIDTH-1:0] pre_cnt;

  assign tick = en & ~clr & (pre_cnt == pre);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone prescaled down-counter timer with one-shot/auto-reload and level irq.
// Optional capture input and CAP register when WB_TIMER_CAPTURE_EN is defined.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic      clk_i,
  input  logic      rst_i,
  wb_timer_if.slave bus,
`ifdef WB_TIMER_CAPTURE_EN
  input  logic      capture_i,
`endif
  output logic      irq_o
);

  // Handshake: an access is taken when cyc&stb are high while ack and err are
  // both low; the next cycle carries exactly one of ack/err for one cycle, so a
  // held strobe is served once every two cycles. Read data and register writes
  // land on the same edge that raises ack.
  logic                      access, reg_hit, wr_hit, rd_hit;
  logic [2:0]                reg_idx;
  logic                      ctrl_wr, load_wr, count_wr, status_wr;
  logic [DATA_WIDTH-1:0]     wmask, ctrl_word, status_word, rdata;
  logic                      en_q, reload_q, ie_q, pend_q;
  logic [PRESCALE_WIDTH-1:0] pre_q, new_pre;
  logic                      new_en, new_reload, new_ie;
  logic [DATA_WIDTH-1:0]     load_q, count_q;
  logic                      presc_en, presc_clr, tick, expiry, cap_pend;
  logic                      unused_addr;

`ifdef WB_TIMER_CAPTURE_EN
  logic [2:0]            cap_sync;
  logic                  cap_rise, cpend_q;
  logic [DATA_WIDTH-1:0] cap_q;
`endif

  assign reg_idx     = bus.wb_addr_i[4:2];
  assign access      = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o & ~bus.wb_err_o;
  assign unused_addr = ^{bus.wb_addr_i[31:5], bus.wb_addr_i[1:0]};
  assign bus.wb_rty_o = 1'b0;
  assign wmask       = DATA_WIDTH'(byte_mask(bus.wb_sel_i));

  always_comb begin
    reg_hit = 1'b0;
    case (reg_idx)
      TMR_CTRL, TMR_LOAD, TMR_COUNT, TMR_STATUS: reg_hit = 1'b1;
`ifdef WB_TIMER_CAPTURE_EN
      TMR_CAP:                                   reg_hit = 1'b1;
`endif
      default:                                   reg_hit = 1'b0;
    endcase
  end

  assign wr_hit    = access & reg_hit & bus.wb_we_i;
  assign rd_hit    = access & reg_hit & ~bus.wb_we_i;
  assign ctrl_wr   = wr_hit & (reg_idx == TMR_CTRL);
  assign load_wr   = wr_hit & (reg_idx == TMR_LOAD);
  assign count_wr  = wr_hit & (reg_idx == TMR_COUNT);
  assign status_wr = wr_hit & (reg_idx == TMR_STATUS);

  // CTRL fields after a byte-lane-masked write
  assign new_en     = wmask[CTRL_EN]     ? bus.wb_data_i[CTRL_EN]     : en_q;
  assign new_reload = wmask[CTRL_RELOAD] ? bus.wb_data_i[CTRL_RELOAD] : reload_q;
  assign new_ie     = wmask[CTRL_IE]     ? bus.wb_data_i[CTRL_IE]     : ie_q;
  assign new_pre    = (pre_q & ~wmask[CTRL_PRE_LSB +: PRESCALE_WIDTH]) |
                      (bus.wb_data_i[CTRL_PRE_LSB +: PRESCALE_WIDTH] &
                       wmask[CTRL_PRE_LSB +: PRESCALE_WIDTH]);

  always_comb begin
    ctrl_word                                  = '0;
    ctrl_word[CTRL_EN]                         = en_q;
    ctrl_word[CTRL_RELOAD]                     = reload_q;
    ctrl_word[CTRL_IE]                         = ie_q;
    ctrl_word[CTRL_PRE_LSB +: PRESCALE_WIDTH]  = pre_q;
  end

  always_comb begin
    status_word              = '0;
    status_word[STATUS_PEND] = pend_q;
`ifdef WB_TIMER_CAPTURE_EN
    status_word[STATUS_CPEND] = cpend_q;
`endif
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      TMR_CTRL:   rdata = ctrl_word;
      TMR_LOAD:   rdata = load_q;
      TMR_COUNT:  rdata = count_q;
      TMR_STATUS: rdata = status_word;
`ifdef WB_TIMER_CAPTURE_EN
      TMR_CAP:    rdata = cap_q;
`endif
      default:    rdata = '0;
    endcase
  end

  // A CTRL write dropping EN kills this cycle's tick; a 0->1 EN write restarts
  // the prescaler so the first period is always full length.
  assign presc_en  = en_q & ~(ctrl_wr & ~new_en);
  assign presc_clr = ctrl_wr & ~en_q & new_en;
  assign expiry    = tick & (count_q == '0);

  wb_timer_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (presc_en),
    .clr   (presc_clr),
    .pre   (pre_q),
    .tick  (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      pre_q    <= '0;
      load_q   <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q     <= new_en;
        reload_q <= new_reload;
        ie_q     <= new_ie;
        pre_q    <= new_pre;
      end else if (expiry && !reload_q) begin
        en_q <= 1'b0;
      end

      if (load_wr) load_q <= (load_q & ~wmask) | (bus.wb_data_i & wmask);

      if (count_wr) begin
        count_q <= (count_q & ~wmask) | (bus.wb_data_i & wmask);
      end else if (tick) begin
        if (count_q != '0)  count_q <= count_q - 1'b1;
        else if (reload_q)  count_q <= load_q;
      end

      // A fresh expiry outranks a software clear in the same cycle
      if (expiry) begin
        pend_q <= 1'b1;
      end else if (status_wr && wmask[STATUS_PEND] && bus.wb_data_i[STATUS_PEND]) begin
        pend_q <= 1'b0;
      end

      irq_o <= ie_q & (pend_q | cap_pend);
    end
  end

`ifdef WB_TIMER_CAPTURE_EN
  assign cap_rise = cap_sync[1] & ~cap_sync[2];
  assign cap_pend = cpend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_sync <= '0;
      cap_q    <= '0;
      cpend_q  <= 1'b0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_i};
      if (cap_rise) begin
        cap_q   <= count_q;
        cpend_q <= 1'b1;
      end else if (status_wr && wmask[STATUS_CPEND] && bus.wb_data_i[STATUS_CPEND]) begin
        cpend_q <= 1'b0;
      end
    end
  end
`else
  assign cap_pend = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.wb_ack_o  <= 1'b0;
      bus.wb_err_o  <= 1'b0;
      bus.wb_data_o <= '0;
    end else begin
      bus.wb_ack_o  <= access & reg_hit;
      bus.wb_err_o  <= access & ~reg_hit;
      bus.wb_data_o <= rd_hit ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: bus driver pushes expected responses, a monitor
// pops and compares them on every ack/err; timing checks sample on negedge.
module tb_wb_timer;

  localparam int W = 36; // {check_data, err, ack, rty, data[31:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
`ifdef WB_TIMER_CAPTURE_EN
  logic capture = 1'b0;
`endif

  wb_timer_if #(.DATA_WIDTH(32)) bus ();

  wb_timer #(
    .DATA_WIDTH     (32),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus.slave),
`ifdef WB_TIMER_CAPTURE_EN
    .capture_i (capture),
`endif
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Monitor: every bus termination must match the oldest expected response
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    logic [W-1:0] got;
    if (bus.wb_ack_o || bus.wb_err_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp ack=%0b err=%0b data=%h", bus.wb_ack_o, bus.wb_err_o,
                 bus.wb_data_o);
      end else begin
        e   = exp_q.pop_front();
        got = {e[35], bus.wb_err_o, bus.wb_ack_o, bus.wb_rty_o, e[35] ? bus.wb_data_o : 32'h0};
        if (got !== e) begin
          n_err++;
          $display("FAIL bus_resp got {chk,err,ack,rty,data}=%h required %h", got, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One access: response edge, then one idle edge; returns 1 time unit after it
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_rdata);
    logic chk;
    chk = !we || exp_err;
    exp_q.push_back({chk, exp_err, !exp_err, 1'b0, (chk && !exp_err) ? exp_rdata : 32'h0});
    bus.wb_addr_i = addr;
    bus.wb_data_i = wdata;
    bus.wb_sel_i  = sel;
    bus.wb_we_i   = we;
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (!(bus.wb_ack_o || bus.wb_err_o)) begin
      n_err++;
      $display("FAIL ack_latency addr=%h got no ack/err 1 cycle after stb, required one", addr);
      for (int i = 0; i < 8 && !(bus.wb_ack_o || bus.wb_err_o); i++) begin
        @(posedge clk); #1;
      end
      if (!(bus.wb_ack_o || bus.wb_err_o) && exp_q.size() > 0) void'(exp_q.pop_back());
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    xfer(1'b1, addr, data, 4'hf, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    xfer(1'b0, addr, 32'h0, 4'hf, 1'b0, exp);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.wb_addr_i = '0;
    bus.wb_data_i = '0;
    bus.wb_sel_i  = '0;
    bus.wb_we_i   = 1'b0;
    bus.wb_cyc_i  = 1'b0;
    bus.wb_stb_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("irq_reset", 32'(irq), 32'h0);
    rd(32'h00, 32'h0);
    rd(32'h04, 32'h0);
    rd(32'h08, 32'h0);
    rd(32'h0C, 32'h0);

    // Auto-reload, PRE=0, LOAD=4: expiry every 5 cycles after enable edge E0
    wr(32'h04, 32'h4);
    wr(32'h08, 32'h4);
    wr(32'h00, 32'h7);           // access at E0, back at E1+1
    negs(5);                     // between E5 and E6: PEND just set
    check("irq_lag", 32'(irq), 32'h0);
    negs(1);                     // between E6 and E7
    check("irq_rise", 32'(irq), 32'h1);
    rd(32'h08, 32'h3);           // access E7: reloaded 4 at E5, 3 after E6
    negs(2);
    wr(32'h0C, 32'h1);           // access E10, same edge as the second expiry
    rd(32'h0C, 32'h1);           // PEND survives the clear
    wr(32'h00, 32'h6);           // access E14: EN off, tick suppressed
    check("irq_held", 32'(irq), 32'h1);
    wr(32'h0C, 32'h1);           // access E16, no expiry
    check("irq_fall", 32'(irq), 32'h0);
    rd(32'h08, 32'h1);
    rd(32'h00, 32'h6);
    rd(32'h0C, 32'h0);

    // One-shot PRE=3, COUNT=2: expiry exactly 12 clocks after enable
    for (int k = 0; k < 2; k++) begin
      wr(32'h0C, 32'h1);
      wr(32'h08, 32'h2);
      wr(32'h00, 32'h0301);
      negs(11 + k);
      rd(32'h0C, 32'(k));
    end
    rd(32'h00, 32'h0300);
    rd(32'h08, 32'h0);
    check("irq_oneshot_ie0", 32'(irq), 32'h0);
    wr(32'h0C, 32'h0);
    rd(32'h0C, 32'h1);
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h0);

    // Reserved offsets, byte lanes, read-as-zero bits
    wr(32'h08, 32'h12345678);
    xfer(1'b1, 32'h14, 32'hFFFFFFFF, 4'hf, 1'b1, 32'h0);
    xfer(1'b0, 32'h14, 32'h0, 4'hf, 1'b1, 32'h0);
    xfer(1'b0, 32'h18, 32'h0, 4'hf, 1'b1, 32'h0);
    xfer(1'b1, 32'h1C, 32'hFFFFFFFF, 4'hf, 1'b1, 32'h0);
`ifndef WB_TIMER_CAPTURE_EN
    xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'hf, 1'b1, 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 4'hf, 1'b1, 32'h0);
`endif
    rd(32'h08, 32'h12345678);
    xfer(1'b1, 32'h08, 32'h0000AB00, 4'b0010, 1'b0, 32'h0);
    rd(32'h08, 32'h1234AB78);
    xfer(1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0);
    rd(32'h08, 32'h1234AB78);
    wr(32'h00, 32'hFFFFFFF8);
    rd(32'h00, 32'h0000FF00);
    wr(32'h04, 32'hCAFEF00D);
    rd(32'h04, 32'hCAFEF00D);
    rd(32'h0C, 32'h0);

`ifdef WB_TIMER_CAPTURE_EN
    // Capture while counting down from 0x20 with PRE=0
    wr(32'h08, 32'h20);
    wr(32'h00, 32'h1);           // access E0, back at E1+1
    capture = 1'b1;              // first sync flop samples at E2
    @(posedge clk);
    @(posedge clk); #1;
    capture = 1'b0;
    @(posedge clk); #1;
    rd(32'h10, 32'h1D);          // captured at E4 from COUNT after E3
    rd(32'h0C, 32'h2);
    wr(32'h10, 32'hFFFFFFFF);
    rd(32'h10, 32'h1D);
    wr(32'h00, 32'h0);
    check("irq_cap_ie0", 32'(irq), 32'h0);
    wr(32'h0C, 32'h2);
    rd(32'h0C, 32'h0);
`endif

    // Reset wins over an access presented on the same edge
    bus.wb_addr_i = 32'h08;
    bus.wb_we_i   = 1'b0;
    bus.wb_sel_i  = 4'hf;
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("ack_err_in_reset", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(32'h08, 32'h0);
    rd(32'h04, 32'h0);
    rd(32'h00, 32'h0);

    negs(2);
    check("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
